// File: rtl/syndrome_calc_if.sv
// Serial codeword input and syndrome result bundle for syndrome_calc.
// The producer of received bits (master) drives the i_* signals; the
// syndrome block (slave) drives the o_* results.
interface syndrome_calc_if #(
  parameter int SYN_W = 10
);
  logic [1:0]       i_code;
  logic             i_start;
  logic             i_bit_valid;
  logic             i_bit;
  logic [SYN_W-1:0] o_S1;
  logic [SYN_W-1:0] o_S3;
  logic [SYN_W-1:0] o_S5;
  logic [SYN_W-1:0] o_S7;
  logic             o_valid;
  logic             o_busy;

  modport master (
    output i_code, i_start, i_bit_valid, i_bit,
    input  o_S1, o_S3, o_S5, o_S7, o_valid, o_busy
  );

  modport slave (
    input  i_code, i_start, i_bit_valid, i_bit,
    output o_S1, o_S3, o_S5, o_S7, o_valid, o_busy
  );
endinterface

// File: rtl/syndrome_calc.sv
// BCH syndrome calculator: accumulates S1, S3, S5, S7 of one serial
// hard-decision codeword by Horner's rule (highest coefficient first).
// Codes: 00 = BCH(63,51) GF(2^6), 01 = BCH(255,239) GF(2^8),
// 10 = BCH(1023,983) GF(2^10). Code 11 is illegal and ignored.
// Field elements are LSB-aligned in SYN_W bits (SYN_W must be >= 10).
module syndrome_calc #(
  parameter int SYN_W = 10,
  parameter int CNT_W = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  syndrome_calc_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] CODE_63   = 2'b00;
  localparam logic [1:0] CODE_255  = 2'b01;
  localparam logic [1:0] CODE_1023 = 2'b10;

  // Multiply a field element by alpha (= x) in the field chosen by code:
  // shift left, fold the overflowing x^m term back with p(x) - x^m.
  function automatic logic [SYN_W-1:0] mul_alpha(input logic [SYN_W-1:0] v,
                                                 input logic [1:0]       code);
    logic [SYN_W-1:0] r;
    r = '0;
    case (code)
      CODE_63:  r[5:0] = {v[4:0], 1'b0} ^ (v[5] ? 6'h03  : 6'h00);
      CODE_255: r[7:0] = {v[6:0], 1'b0} ^ (v[7] ? 8'h1d  : 8'h00);
      default:  r[9:0] = {v[8:0], 1'b0} ^ (v[9] ? 10'h009 : 10'h000);
    endcase
    return r;
  endfunction

  // Multiply by alpha^pow; pow is a constant at every call site, so this
  // unrolls into a fixed XOR network per field.
  function automatic logic [SYN_W-1:0] mul_alpha_pow(input logic [SYN_W-1:0] v,
                                                     input logic [1:0]       code,
                                                     input int               pow);
    logic [SYN_W-1:0] r;
    r = v;
    for (int k = 0; k < pow; k++) begin
      r = mul_alpha(r, code);
    end
    return r;
  endfunction

  // Counter value of the final coefficient (r_0) for each code: N-1.
  function automatic logic [CNT_W-1:0] last_index(input logic [1:0] code);
    case (code)
      CODE_63:  return CNT_W'(62);
      CODE_255: return CNT_W'(254);
      default:  return CNT_W'(1022);
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [1:0]       code_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SYN_W-1:0] s1_q, s3_q, s5_q, s7_q;
  logic             valid_q, busy_q;

  logic             start_ok;
  logic             accept;
  logic             last_bit;
  logic [SYN_W-1:0] bit_ext;

  // A legal start restarts from any state; the start cycle never takes a bit.
  assign start_ok = bus.i_start && (bus.i_code != 2'b11);
  assign accept   = (state_q == ACC) && bus.i_bit_valid && !start_ok;
  assign last_bit = accept && (cnt_q == last_index(code_q));
  assign bit_ext  = {{(SYN_W-1){1'b0}}, bus.i_bit};

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: every clocked register uses <= so all flops sample the same
      // pre-edge values; a blocking = here would create order-dependent races.
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: the default assignment first means every path drives state_d,
    // so no latch is inferred for the cases that do not change state.
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_ok) state_d = ACC;
      ACC: begin
        if (start_ok)      state_d = ACC;
        else if (last_bit) state_d = DONE;
      end
      DONE: if (start_ok) state_d = ACC;
      default: state_d = IDLE;
    endcase
  end

  // Syndrome accumulators, bit counter, latched code and status flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      code_q  <= 2'b00;
      cnt_q   <= '0;
      s1_q    <= '0;
      s3_q    <= '0;
      s5_q    <= '0;
      s7_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (start_ok) begin
      code_q  <= bus.i_code;
      cnt_q   <= '0;
      s1_q    <= '0;
      s3_q    <= '0;
      s5_q    <= '0;
      s7_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b1;
    end else if (accept) begin
      cnt_q <= cnt_q + 1'b1;
      s1_q  <= mul_alpha_pow(s1_q, code_q, 1) ^ bit_ext;
      s3_q  <= mul_alpha_pow(s3_q, code_q, 3) ^ bit_ext;
      // S5/S7 only exist for the t=4 code; keep them at zero otherwise.
      if (code_q == CODE_1023) begin
        s5_q <= mul_alpha_pow(s5_q, code_q, 5) ^ bit_ext;
        s7_q <= mul_alpha_pow(s7_q, code_q, 7) ^ bit_ext;
      end else begin
        s5_q <= '0;
        s7_q <= '0;
      end
      if (last_bit) begin
        valid_q <= 1'b1;
        busy_q  <= 1'b0;
      end
    end
  end

  assign bus.o_S1    = s1_q;
  assign bus.o_S3    = s3_q;
  assign bus.o_S5    = s5_q;
  assign bus.o_S7    = s7_q;
  assign bus.o_valid = valid_q;
  assign bus.o_busy  = busy_q;

endmodule

// File: tb/tb_syndrome_calc.sv
// Self-checking bench for syndrome_calc. The reference model evaluates
// S_j = sum over set bits r_i of alpha^(j*i) using a generic GF multiply
// and a power table, independent of the serial Horner structure.
module tb_syndrome_calc;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  syndrome_calc_if #(.SYN_W(10)) bus ();

  syndrome_calc #(.SYN_W(10), .CNT_W(10)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Received word indexed by coefficient: word[i] is r_i.
  bit         word [0:1022];
  logic [9:0] pw   [0:1022];

  function automatic int nlen(input logic [1:0] code);
    case (code)
      2'b00:   return 63;
      2'b01:   return 255;
      default: return 1023;
    endcase
  endfunction

  // Carry-less multiply followed by polynomial long-division reduction.
  function automatic logic [9:0] gf_mult(input logic [9:0] a, input logic [9:0] b,
                                         input logic [1:0] code);
    logic [19:0] p;
    logic [19:0] poly;
    int m;
    p = '0;
    for (int i = 0; i < 10; i++) if (b[i]) p = p ^ (20'(a) << i);
    case (code)
      2'b00:   begin m = 6;  poly = 20'h00043; end
      2'b01:   begin m = 8;  poly = 20'h0011d; end
      default: begin m = 10; poly = 20'h00409; end
    endcase
    for (int k = 19; k >= m; k--) if (p[k]) p = p ^ (poly << (k - m));
    return p[9:0];
  endfunction

  task automatic model_syn(input logic [1:0] code, output logic [9:0] e1,
                           output logic [9:0] e3, output logic [9:0] e5,
                           output logic [9:0] e7);
    int n;
    n = nlen(code);
    pw[0] = 10'h001;
    for (int k = 1; k < n; k++) pw[k] = gf_mult(pw[k-1], 10'h002, code);
    e1 = '0; e3 = '0; e5 = '0; e7 = '0;
    for (int i = 0; i < n; i++) begin
      if (word[i]) begin
        e1 ^= pw[(1 * i) % n];
        e3 ^= pw[(3 * i) % n];
        if (code == 2'b10) begin
          e5 ^= pw[(5 * i) % n];
          e7 ^= pw[(7 * i) % n];
        end
      end
    end
  endtask

  task automatic clear_word();
    for (int i = 0; i < 1023; i++) word[i] = 1'b0;
  endtask

  // Start a codeword and stream word[N-1..0]; checks latency, status and
  // syndromes against the model, then checks that DONE holds the result.
  task automatic run_codeword(input logic [1:0] code, input bit gaps, input string name);
    int n, cyc, exp_cyc;
    bit early;
    logic [9:0] e1, e3, e5, e7;
    logic [9:0] h1;
    n = nlen(code);
    early = 1'b0;
    @(negedge clk);
    bus.i_code = code; bus.i_start = 1'b1;
    bus.i_bit_valid = 1'b1; bus.i_bit = 1'b1;   // must not be taken on the start cycle
    @(negedge clk);
    bus.i_start = 1'b0;
    cyc = 1;
    checks++;
    if (bus.o_busy !== 1'b1 || bus.o_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s start: busy=%b valid=%b expected busy=1 valid=0", name, bus.o_busy, bus.o_valid);
    end
    for (int i = n - 1; i >= 0; i--) begin
      if (bus.o_valid) early = 1'b1;
      bus.i_bit_valid = 1'b1; bus.i_bit = word[i];
      @(negedge clk); cyc++;
      if (gaps && i > 0) begin
        if (bus.o_valid) early = 1'b1;
        bus.i_bit_valid = 1'b0; bus.i_bit = 1'($urandom);
        @(negedge clk); cyc++;
      end
    end
    bus.i_bit_valid = 1'b0;
    exp_cyc = gaps ? (2 * n) : (n + 1);
    checks++;
    if (early) begin
      failures++;
      $display("FAIL %s early_valid: o_valid rose before the last bit, expected 0", name);
    end
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_busy !== 1'b0 || cyc != exp_cyc) begin
      failures++;
      $display("FAIL %s done: valid=%b busy=%b cycles=%0d expected valid=1 busy=0 cycles=%0d",
               name, bus.o_valid, bus.o_busy, cyc, exp_cyc);
    end
    model_syn(code, e1, e3, e5, e7);
    checks++;
    if (bus.o_S1 !== e1 || bus.o_S3 !== e3 || bus.o_S5 !== e5 || bus.o_S7 !== e7) begin
      failures++;
      $display("FAIL %s syndromes: S1=%h S3=%h S5=%h S7=%h expected %h %h %h %h",
               name, bus.o_S1, bus.o_S3, bus.o_S5, bus.o_S7, e1, e3, e5, e7);
    end
    h1 = bus.o_S1;
    for (int k = 0; k < 4; k++) begin
      bus.i_bit_valid = 1'($urandom); bus.i_bit = 1'($urandom);
      @(negedge clk);
    end
    bus.i_bit_valid = 1'b0;
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_S1 !== e1 || bus.o_S3 !== e3) begin
      failures++;
      $display("FAIL %s hold: valid=%b S1=%h S3=%h expected 1 %h %h (first S1 %h)",
               name, bus.o_valid, bus.o_S1, bus.o_S3, e1, e3, h1);
    end
  endtask

  task automatic test_reset();
    bus.i_code = 2'b00; bus.i_start = 1'b0; bus.i_bit_valid = 1'b0; bus.i_bit = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.o_S1 !== 0 || bus.o_S3 !== 0 || bus.o_S5 !== 0 || bus.o_S7 !== 0 ||
        bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset: S1=%h S3=%h S5=%h S7=%h valid=%b busy=%b expected all 0",
               bus.o_S1, bus.o_S3, bus.o_S5, bus.o_S7, bus.o_valid, bus.o_busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_illegal_code();
    @(negedge clk);
    bus.i_code = 2'b11; bus.i_start = 1'b1; bus.i_bit_valid = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    @(negedge clk);
    bus.i_bit_valid = 1'b0;
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0) begin
      failures++;
      $display("FAIL illegal_idle: busy=%b valid=%b expected 0 0", bus.o_busy, bus.o_valid);
    end
  endtask

  task automatic test_code10_zeros();
    clear_word();
    run_codeword(2'b10, 1'b0, "c10_zeros");
    checks++;
    if (bus.o_S1 !== 0 || bus.o_S3 !== 0 || bus.o_S5 !== 0 || bus.o_S7 !== 0) begin
      failures++;
      $display("FAIL c10_zeros_const: S1=%h S3=%h S5=%h S7=%h expected 000",
               bus.o_S1, bus.o_S3, bus.o_S5, bus.o_S7);
    end
    // An illegal start in DONE must leave the result in place.
    bus.i_code = 2'b11; bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_busy !== 1'b0) begin
      failures++;
      $display("FAIL illegal_done: valid=%b busy=%b expected 1 0", bus.o_valid, bus.o_busy);
    end
  endtask

  task automatic test_code00_single();
    clear_word(); word[0] = 1'b1;
    run_codeword(2'b00, 1'b0, "c00_r0");
    checks++;
    if (bus.o_S1 !== 10'h001 || bus.o_S3 !== 10'h001 || bus.o_S5 !== 0 || bus.o_S7 !== 0) begin
      failures++;
      $display("FAIL c00_r0_const: S1=%h S3=%h S5=%h S7=%h expected 001 001 000 000",
               bus.o_S1, bus.o_S3, bus.o_S5, bus.o_S7);
    end
    clear_word(); word[1] = 1'b1;
    run_codeword(2'b00, 1'b0, "c00_r1");
    checks++;
    if (bus.o_S1 !== 10'h002 || bus.o_S3 !== 10'h008) begin
      failures++;
      $display("FAIL c00_r1_const: S1=%h S3=%h expected 002 008", bus.o_S1, bus.o_S3);
    end
  endtask

  task automatic test_code10_single();
    clear_word(); word[1] = 1'b1;
    run_codeword(2'b10, 1'b0, "c10_r1");
    checks++;
    if (bus.o_S1 !== 10'h002 || bus.o_S3 !== 10'h008 || bus.o_S5 !== 10'h020 || bus.o_S7 !== 10'h080) begin
      failures++;
      $display("FAIL c10_r1_const: S1=%h S3=%h S5=%h S7=%h expected 002 008 020 080",
               bus.o_S1, bus.o_S3, bus.o_S5, bus.o_S7);
    end
    clear_word(); word[10] = 1'b1;
    run_codeword(2'b10, 1'b0, "c10_r10");
    checks++;
    if (bus.o_S1 !== 10'h009) begin
      failures++;
      $display("FAIL c10_r10_const: S1=%h expected 009", bus.o_S1);
    end
  endtask

  task automatic test_gaps();
    clear_word(); word[1] = 1'b1;
    run_codeword(2'b01, 1'b1, "c01_gaps");
    checks++;
    if (bus.o_S1 !== 10'h002 || bus.o_S3 !== 10'h008) begin
      failures++;
      $display("FAIL c01_gaps_const: S1=%h S3=%h expected 002 008", bus.o_S1, bus.o_S3);
    end
  endtask

  task automatic test_abort_restart();
    bit early;
    early = 1'b0;
    @(negedge clk);
    bus.i_code = 2'b00; bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      bus.i_bit_valid = 1'b1; bus.i_bit = 1'($urandom);
      @(negedge clk);
      if (bus.o_valid) early = 1'b1;
    end
    bus.i_bit_valid = 1'b0;
    checks++;
    if (early || bus.o_busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_partial: early_valid=%b busy=%b expected 0 1", early, bus.o_busy);
    end
    clear_word();
    run_codeword(2'b10, 1'b0, "abort_restart");
  endtask

  task automatic test_reset_mid_acc();
    @(negedge clk);
    bus.i_code = 2'b00; bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      bus.i_bit_valid = 1'b1; bus.i_bit = 1'($urandom);
      @(negedge clk);
    end
    bus.i_bit_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_S1 !== 0 || bus.o_S3 !== 0 || bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: S1=%h S3=%h busy=%b valid=%b expected 0",
               bus.o_S1, bus.o_S3, bus.o_busy, bus.o_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_bit_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.i_bit_valid = 1'b0;
    checks++;
    if (bus.o_S1 !== 0 || bus.o_S3 !== 0 || bus.o_S5 !== 0 || bus.o_S7 !== 0 ||
        bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: S1=%h S3=%h S5=%h S7=%h busy=%b valid=%b expected all 0",
               bus.o_S1, bus.o_S3, bus.o_S5, bus.o_S7, bus.o_busy, bus.o_valid);
    end
    clear_word();
    run_codeword(2'b01, 1'b0, "after_reset_c01");
  endtask

  task automatic test_random();
    logic [1:0] code;
    int n, nerr;
    for (int t = 0; t < 8; t++) begin
      code = 2'($urandom_range(0, 2));
      n = nlen(code);
      clear_word();
      if (t % 3 == 2) begin
        for (int i = 0; i < n; i++) word[i] = 1'($urandom);
      end else begin
        nerr = $urandom_range(1, 5);
        for (int e = 0; e < nerr; e++) word[$urandom_range(0, n - 1)] = 1'b1;
      end
      run_codeword(code, 1'($urandom), "random");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_illegal_code();
    test_code10_zeros();
    test_code00_single();
    test_code10_single();
    test_gaps();
    test_abort_restart();
    test_reset_mid_acc();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
